// File: rtl/seg_scan_driver.sv
// Multiplexed driver for two 4-digit 7-segment banks: scans digit pairs (sel+4, sel),
// snapshots the character/blink inputs once per frame, and blanks blinking digits.
package seg_scan_pkg;
   typedef enum logic [4:0] {
      CHAR_0   = 5'd0,
      CHAR_1   = 5'd1,
      CHAR_2   = 5'd2,
      CHAR_3   = 5'd3,
      CHAR_4   = 5'd4,
      CHAR_5   = 5'd5,
      CHAR_6   = 5'd6,
      CHAR_7   = 5'd7,
      CHAR_8   = 5'd8,
      CHAR_9   = 5'd9,
      CHAR_A   = 5'd10,
      CHAR_B   = 5'd11,
      CHAR_C   = 5'd12,
      CHAR_D   = 5'd13,
      CHAR_E   = 5'd14,
      CHAR_F   = 5'd15,
      CHAR_H   = 5'd16,
      CHAR_BLK = 5'd31
   } code_t;
endpackage

module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 25_000,
   parameter int unsigned BLINK_DIV = 25_000_000,
   parameter int unsigned GUARD     = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  code_t      seg_data [7:0],
   input  logic [7:0] seg_blink,
   output logic [7:0] seg_an,
   output logic [7:0] seg_l,
   output logic [7:0] seg_r
);

   localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [SW-1:0] slot_cnt_q, slot_cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic          valid_q, valid_d;
   code_t         shadow_q [7:0];
   code_t         shadow_d [7:0];
   logic [7:0]    shblink_q, shblink_d;
   logic [7:0]    an_q, an_d;
   logic [7:0]    l_q, l_d;
   logic [7:0]    r_q, r_d;

   logic          slot_wrap, frame_wrap, blink_wrap;
   logic [2:0]    l_idx, r_idx;

   function automatic logic [7:0] decode(input code_t c);
      logic [7:0] s;
      case (c)
         CHAR_0:  s = 8'h3F;
         CHAR_1:  s = 8'h06;
         CHAR_2:  s = 8'h5B;
         CHAR_3:  s = 8'h4F;
         CHAR_4:  s = 8'h66;
         CHAR_5:  s = 8'h6D;
         CHAR_6:  s = 8'h7D;
         CHAR_7:  s = 8'h07;
         CHAR_8:  s = 8'h7F;
         CHAR_9:  s = 8'h6F;
         CHAR_A:  s = 8'h77;
         CHAR_B:  s = 8'h7C;
         CHAR_C:  s = 8'h39;
         CHAR_D:  s = 8'h5E;
         CHAR_E:  s = 8'h79;
         CHAR_F:  s = 8'h71;
         CHAR_H:  s = 8'h76;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_wrap   = (slot_cnt_q == SW'(SCAN_DIV - 1));
      frame_wrap  = slot_wrap && (sel_q == 2'd3);
      blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));

      slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
      sel_d       = slot_wrap ? sel_q + 2'd1 : sel_q;
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q ^ blink_wrap;

      shadow_d    = shadow_q;
      shblink_d   = shblink_q;
      if (frame_wrap) begin
         shadow_d  = seg_data;
         shblink_d = seg_blink;
      end
      // Anodes stay dark until the first snapshot so the blank power-up frame shows nothing.
      valid_d     = valid_q | frame_wrap;
   end

   // Output registers are fed from next-state values so they track the new slot on its first cycle.
   always_comb begin
      l_idx = {1'b1, sel_d};
      r_idx = {1'b0, sel_d};
      l_d   = (blink_phase_d && shblink_d[l_idx]) ? '0 : decode(shadow_d[l_idx]);
      r_d   = (blink_phase_d && shblink_d[r_idx]) ? '0 : decode(shadow_d[r_idx]);
      if (!valid_d || (slot_cnt_d < SW'(GUARD))) begin
         an_d = '0;
      end else begin
         an_d = (8'h01 << l_idx) | (8'h01 << r_idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q    <= '0;
         sel_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         valid_q       <= 1'b0;
         shadow_q      <= '{default: CHAR_BLK};
         shblink_q     <= '0;
         an_q          <= '0;
         l_q           <= '0;
         r_q           <= '0;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         sel_q         <= sel_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         valid_q       <= valid_d;
         shadow_q      <= shadow_d;
         shblink_q     <= shblink_d;
         an_q          <= an_d;
         l_q           <= l_d;
         r_q           <= r_d;
      end
   end

   assign seg_an = an_q;
   assign seg_l  = l_q;
   assign seg_r  = r_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_DIV=32, GUARD=1.
module tb_seg_scan_driver;
   import seg_scan_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   code_t      data [7:0];
   logic [7:0] blink;
   logic [7:0] an, l, r;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(32), .GUARD(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .seg_data (data),
      .seg_blink(blink),
      .seg_an   (an),
      .seg_l    (l),
      .seg_r    (r)
   );

   task automatic fill(input code_t c);
      for (int i = 0; i < 8; i++) data[i] = c;
   endtask

   // Cycle k = state after k rising edges since reset release; sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   // Expected anodes for data already snapshotted at cycle 15.
   function automatic logic [7:0] exp_an(input int c);
      int s;
      if (c < 16 || (c % 4) == 0) return 8'h00;
      s = (c / 4) % 4;
      return (8'h10 << s) | (8'h01 << s);
   endfunction

   task automatic test_reset();
      fill(CHAR_8);
      blink = 8'h00;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (an !== 8'h00) begin n_bad++; $display("FAIL reset_an got %h want 00", an); end
      n_cmp++; if (l  !== 8'h00) begin n_bad++; $display("FAIL reset_l got %h want 00", l); end
      n_cmp++; if (r  !== 8'h00) begin n_bad++; $display("FAIL reset_r got %h want 00", r); end
   endtask

   task automatic test_scan();
      fill(CHAR_8);
      blink = 8'h00;
      do_reset();
      for (int c = 0; c < 32; c++) begin
         run_to(c);
         n_cmp++;
         if (an !== exp_an(c)) begin n_bad++; $display("FAIL scan_an cyc=%0d got %h want %h", c, an, exp_an(c)); end
         if (c >= 16) begin
            n_cmp++; if (l !== 8'h7F) begin n_bad++; $display("FAIL scan_l cyc=%0d got %h want 7f", c, l); end
            n_cmp++; if (r !== 8'h7F) begin n_bad++; $display("FAIL scan_r cyc=%0d got %h want 7f", c, r); end
         end
      end
   endtask

   task automatic test_pattern();
      logic [7:0] exp_l [4];
      exp_l[0] = 8'h3F; exp_l[1] = 8'h06; exp_l[2] = 8'h79; exp_l[3] = 8'h76;
      fill(CHAR_BLK);
      data[7] = CHAR_H; data[6] = CHAR_E; data[5] = CHAR_1; data[4] = CHAR_0;
      blink = 8'h00;
      do_reset();
      for (int c = 16; c < 32; c++) begin
         run_to(c);
         n_cmp++; if (an !== exp_an(c)) begin n_bad++; $display("FAIL pat_an cyc=%0d got %h want %h", c, an, exp_an(c)); end
         n_cmp++; if (l !== exp_l[(c/4)%4]) begin n_bad++; $display("FAIL pat_l cyc=%0d got %h want %h", c, l, exp_l[(c/4)%4]); end
         n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL pat_r cyc=%0d got %h want 00", c, r); end
      end
   endtask

   task automatic test_blink();
      logic [7:0] want_l;
      fill(CHAR_1);
      blink = 8'h80;
      do_reset();
      for (int c = 16; c < 96; c++) begin
         run_to(c);
         want_l = (((c / 4) % 4) == 3 && ((c / 32) % 2) == 1) ? 8'h00 : 8'h06;
         n_cmp++; if (an !== exp_an(c)) begin n_bad++; $display("FAIL blink_an cyc=%0d got %h want %h", c, an, exp_an(c)); end
         n_cmp++; if (l !== want_l) begin n_bad++; $display("FAIL blink_l cyc=%0d got %h want %h", c, l, want_l); end
         n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL blink_r cyc=%0d got %h want 06", c, r); end
      end
   endtask

   task automatic test_tearing();
      logic [7:0] want;
      fill(CHAR_0);
      blink = 8'h00;
      do_reset();
      for (int c = 16; c < 48; c++) begin
         run_to(c);
         if (c == 21) begin
            fill(CHAR_1);
            blink = 8'hFF;
         end
         if (c == 31) blink = 8'h00;
         want = (c < 32) ? 8'h3F : 8'h06;
         n_cmp++; if (l !== want) begin n_bad++; $display("FAIL tear_l cyc=%0d got %h want %h", c, l, want); end
         n_cmp++; if (r !== want) begin n_bad++; $display("FAIL tear_r cyc=%0d got %h want %h", c, r, want); end
      end
   endtask

   task automatic test_mid_reset();
      fill(CHAR_8);
      blink = 8'h00;
      do_reset();
      run_to(26);
      n_cmp++; if (an !== 8'h44) begin n_bad++; $display("FAIL mrst_pre_an got %h want 44", an); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (an !== 8'h00) begin n_bad++; $display("FAIL mrst_an got %h want 00", an); end
      n_cmp++; if (l  !== 8'h00) begin n_bad++; $display("FAIL mrst_l got %h want 00", l); end
      n_cmp++; if (r  !== 8'h00) begin n_bad++; $display("FAIL mrst_r got %h want 00", r); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      for (int c = 0; c < 24; c++) begin
         run_to(c);
         n_cmp++; if (an !== exp_an(c)) begin n_bad++; $display("FAIL mrst_scan_an cyc=%0d got %h want %h", c, an, exp_an(c)); end
         if (c < 16) begin
            n_cmp++; if (l !== 8'h00) begin n_bad++; $display("FAIL mrst_blank_l cyc=%0d got %h want 00", c, l); end
         end else begin
            n_cmp++; if (l !== 8'h7F) begin n_bad++; $display("FAIL mrst_scan_l cyc=%0d got %h want 7f", c, l); end
         end
      end
   endtask

   task automatic test_illegal();
      logic [7:0] want_r;
      fill(CHAR_8);
      data[0] = code_t'(5'd20);
      blink = 8'h00;
      do_reset();
      for (int c = 16; c < 32; c++) begin
         run_to(c);
         want_r = (((c / 4) % 4) == 0) ? 8'h00 : 8'h7F;
         n_cmp++; if (an !== exp_an(c)) begin n_bad++; $display("FAIL ill_an cyc=%0d got %h want %h", c, an, exp_an(c)); end
         n_cmp++; if (l !== 8'h7F) begin n_bad++; $display("FAIL ill_l cyc=%0d got %h want 7f", c, l); end
         n_cmp++; if (r !== want_r) begin n_bad++; $display("FAIL ill_r cyc=%0d got %h want %h", c, r, want_r); end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_pattern();
      test_blink();
      test_tearing();
      test_mid_reset();
      test_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
